// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and the reference round-robin pick for the FIFO write arbiter.
// Latency: none (types and functions only). Backpressure: not applicable.
// Package name fifo_arb_pkg is shared with other arbiters built on rr_priority_sel.
package fifo_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        BURST = ST_BURST
    } arb_state_t;

    localparam int RR_MAX_REQ = 32;

    // First set bit of req scanning ptr+1, ptr+2, ... (mod n); returns ptr when req is empty.
    function automatic int rr_pick(input logic [RR_MAX_REQ-1:0] req, input int ptr, input int n);
        int idx;
        idx = ptr;
        for (int k = n; k >= 1; k--) begin
            if (req[(ptr + k) % n]) begin
                idx = (ptr + k) % n;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer lanes, FIFO write port and grant status bundled for the write arbiter.
// Latency: none (wiring only). Backpressure: fifo_write_ready gates req_ready.
// master = arbiter side, slave = producers/FIFO/observer side.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 8
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_write_req;
    logic [DATA_WIDTH-1:0]         fifo_write_data;
    logic                          fifo_write_ready;
    logic                          fifo_almost_full;
    logic                          grant_valid;
    logic [ID_W-1:0]               grant_id;
    logic [CNT_W-1:0]              beat_cnt;

    modport master (
        input  req_valid, req_data, req_last, fifo_write_ready, fifo_almost_full,
        output req_ready, fifo_write_req, fifo_write_data, grant_valid, grant_id, beat_cnt
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_write_ready, fifo_almost_full,
        input  req_ready, fifo_write_req, fifo_write_data, grant_valid, grant_id, beat_cnt
    );

endinterface

// File: rtl/fifo_write_arbiter_sel.sv
// Combinational round-robin picker: first request after ptr, plus a found flag.
// Latency: 0 cycles (pure combinational). Backpressure: none; caller qualifies use.
module rr_priority_sel #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    int          start;
    logic [N-1:0] rot;

    always_comb begin
        start = (int'(ptr) + 1) % N;
        // Rotating so the lane just after ptr lands at bit 0 turns RR into a fixed-priority scan.
        rot   = N'({req, req} >> start);
        idx   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = IW'((start + k) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Latency: 1-cycle grant after request, then zero-latency pass-through; one idle bubble between bursts.
// Backpressure: fifo_write_ready stalls the owner; FIFO_ARB_AF_THROTTLE_EN holds off new grants on almost_full.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 8,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_write_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [ID_W-1:0]  PTR_RST = ID_W'(NUM_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic             grant_ok;
    logic             own_valid;
    logic             own_last;
    logic             accept;

    rr_priority_sel #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_sel (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef FIFO_ARB_AF_THROTTLE_EN
    assign grant_ok = pick_found & ~bus.fifo_almost_full;
`else
    logic af_unused;
    assign af_unused = bus.fifo_almost_full;
    assign grant_ok  = pick_found;
`endif

    assign own_valid = bus.req_valid[grant_id_q];
    assign own_last  = bus.req_last[grant_id_q];

    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        grant_id_d          = grant_id_q;
        beat_cnt_d          = beat_cnt_q;
        accept              = 1'b0;
        bus.req_ready       = '0;
        bus.fifo_write_req  = 1'b0;
        bus.fifo_write_data = bus.req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];

        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                // Owner sees ready even while idle so the grant is held without preemption.
                bus.req_ready[grant_id_q] = bus.fifo_write_ready;
                accept                    = own_valid & bus.fifo_write_ready;
                bus.fifo_write_req        = accept;
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (own_last || (beat_cnt_d == MAX_CNT)) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= PTR_RST;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.grant_valid = (state_q == BURST);
    assign bus.grant_id    = grant_id_q;
    assign bus.beat_cnt    = beat_cnt_q;

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of one `fifo` instance between NUM_REQ producers.
- Arbitration is round-robin. The grant is held for a burst that ends on `req_last` or after MAX_BURST accepted beats.
- Sits between producer lanes (e.g. per-PE result streams) and a shared output FIFO.
- The FIFO's full/ready flags are the only backpressure source.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 64, beat width; must match the FIFO DATA_WIDTH.
- MAX_BURST, 8, maximum beats per grant (>=1).
- ID_W, $clog2(NUM_REQ), grant index width (derived; do not override).
- CNT_W, $clog2(MAX_BURST+1), beat counter width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed beats; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  marks the final beat of lane i's burst.
- req_ready  out  NUM_REQ  beat accepted from lane i this cycle.
- fifo_write_req  out  1  drives the FIFO `s_write_req`.
- fifo_write_data  out  DATA_WIDTH  drives the FIFO `s_write_data`.
- fifo_write_ready  in  1  from the FIFO `s_write_ready` (!full).
- fifo_almost_full  in  1  from the FIFO `almost_full`.
- grant_valid  out  1  a burst is owned (state BURST).
- grant_id  out  ID_W  current owner index.
- beat_cnt  out  CNT_W  beats accepted in the current burst.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, rr_ptr=NUM_REQ-1, grant_id=0, beat_cnt=0, grant_valid=0.
  - req_ready=0, fifo_write_req=0.
- FSM state IDLE:
  - If any req_valid is set, select the first asserted lane scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
  - Register the selection into grant_id, clear beat_cnt, go to BURST next cycle.
  - Arbitration latency is 1 cycle: a request at cycle t gets its earliest accepted beat at t+1.
- FSM state BURST (combinational outputs, owner o=grant_id):
  - fifo_write_req = req_valid[o] & fifo_write_ready.
  - req_ready[o] = fifo_write_ready; req_ready of every non-owner lane = 0.
  - fifo_write_data = lane o of req_data (combinational mux; zero-latency pass-through).
- Accepted beat: req_valid[o] & req_ready[o]. Each accepted beat increments beat_cnt.
- Burst termination: an accepted beat with req_last[o]=1, OR an accepted beat that makes beat_cnt==MAX_BURST.
  - On termination: rr_ptr<=o, next state IDLE.
  - Exactly one IDLE bubble cycle separates bursts.
- Owner deasserts valid mid-burst: the grant is held indefinitely; no timeout and no preemption.
- FIFO full (fifo_write_ready=0): fifo_write_req=0 and all req_ready=0; the burst stalls and beat_cnt holds.
- MAX_BURST=1: every accepted beat terminates the burst, giving pure per-beat round-robin with bubbles.
- A req_last on a non-owner lane is ignored.
- Non-owner valid/data may change freely; nothing is latched from non-owner lanes.
- Reset mid-burst returns to IDLE immediately. Any beat accepted in that cycle is lost; producers must also be reset.
- Invariants:
  - At most one req_ready bit is set per cycle.
  - fifo_write_req is never asserted while fifo_write_ready=0.

Optional Feature:
- Macro: FIFO_ARB_AF_THROTTLE_EN.
- Defined:
  - In IDLE, no new grant is issued while fifo_almost_full=1; the arbiter stays in IDLE and rr_ptr is unchanged.
  - A burst already in progress continues until it terminates.
- Undefined: fifo_almost_full is unused; grants are issued regardless.

Decomposition:
- Shared package `fifo_arb_pkg` holds:
  - typedef arb_state_t {IDLE, BURST}.
  - the state encoding constants.
  - function rr_pick(req, ptr) returning the index.
- One sub-module: `rr_priority_sel`. It is the combinational round-robin picker (rotate request vector by ptr+1, find first one, rotate back) plus a found flag. It is reused by other arbiters.

Test Plan:
- Single lane: lane 2 sends 3 beats, last on the 3rd, FIFO always ready.
  - grant_id=2 one cycle after valid; 3 consecutive writes; IDLE bubble; rr_ptr=2.
- All 4 lanes valid continuously, MAX_BURST=8, no req_last.
  - Grant order 0,1,2,3,0; each burst exactly 8 writes; one bubble between bursts.
- Backpressure: fifo_write_ready held 0 for cycles 3-6 of a burst.
  - fifo_write_req=0 and req_ready=0 on those cycles; beat_cnt holds; no data lost or duplicated; beat order preserved.
- Owner drops valid for 5 cycles mid-burst while lane 1 is valid.
  - Grant stays with the owner; lane 1 req_ready=0 throughout.
- Async reset pulsed mid-burst at beat 4.
  - All outputs at reset values within the same cycle; after release, lane 0 wins first if valid (rr_ptr=NUM_REQ-1).
- With FIFO_ARB_AF_THROTTLE_EN: fifo_almost_full=1 in IDLE with lanes valid.
  - No grant while it is high; grant issued the cycle after it drops.
  - Without the macro, the same stimulus produces a grant after 1 cycle.
